sender_twoff: RTL

- Transmit-side stage of the two-flop clock-domain-crossing link, in the sender clock domain.
- Buffers words from a local producer in a small FIFO.
- Presents each word on a held-stable data bus and runs a 4-phase req/ack handshake with the downstream receiver.
- The receiver's ack is synchronized with two flops before use.

---
 rtl/sender_twoff_pkg.sv | 14 +
 rtl/dffs.sv | 14 +
 rtl/sender_twoff_fifo_sync.sv | 48 ++++
 rtl/sender_twoff.sv | 113 +++++++++++
 4 files changed

// File: rtl/sender_twoff_pkg.sv
// Shared constants and FSM state encoding for the sender_twoff CDC transmit stage.
package sender_twoff_pkg;

    localparam int unsigned DEF_DATA_MSB = 7;
    localparam int unsigned DEF_FIFO_AW  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_REQ  = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

endpackage

// File: rtl/dffs.sv
// Single-bit D flop with synchronous active-low reset; used as a synchronizer stage.
module dffs (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (!reset) q <= 1'b0;
        else        q <= d;
    end

endmodule

// File: rtl/sender_twoff_fifo_sync.sv
// Small synchronous FIFO with occupancy counter; full/empty derive from the count.
module fifo_sync #(
    parameter int unsigned DATA_MSB = 7,
    parameter int unsigned FIFO_AW  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_MSB:0] wdata,
    output logic [DATA_MSB:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

    logic [DATA_MSB:0] mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (FIFO_AW+1)'(1);
                2'b01:   count <= count - (FIFO_AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sender_twoff.sv
// Sender-domain side of the two-flop CDC link: FIFO-buffered words sent over a 4-phase req/ack handshake.
// Optional SENDER_TWOFF_STATS_EN adds the xfer_cnt transfer counter and the drop overflow pulse.
module sender_twoff
    import sender_twoff_pkg::*;
#(
    parameter int unsigned DATA_MSB = DEF_DATA_MSB,
    parameter int unsigned FIFO_AW  = DEF_FIFO_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vi,
    input  logic [DATA_MSB:0] wdata,
    output logic              full,
    output logic              req,
    output logic [DATA_MSB:0] tdata,
    input  logic              ack,
    output logic              done
`ifdef SENDER_TWOFF_STATS_EN
    ,
    output logic [15:0]       xfer_cnt,
    output logic              drop
`endif
);

    logic              a1;
    logic              a2;
    logic              push;
    logic              pop;
    logic              empty;
    logic [DATA_MSB:0] head;
    state_t            state;
    state_t            state_d;
    logic              req_d;
    logic              done_d;

    dffs u_sync1 (.clk(clk), .reset(reset), .d(ack), .q(a1));
    dffs u_sync2 (.clk(clk), .reset(reset), .d(a1),  .q(a2));

    // full is the pre-pop value, so a write while full is dropped even on a pop edge
    assign push = vi & ~full;

    fifo_sync #(
        .DATA_MSB(DATA_MSB),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .wdata(wdata),
        .rdata(head),
        .full (full),
        .empty(empty)
    );

    always_comb begin
        state_d = state;
        req_d   = req;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state)
            ST_IDLE: begin
                req_d = 1'b0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                req_d   = 1'b1;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                req_d = 1'b1;
                if (a2) begin
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                req_d = 1'b0;
                if (!a2) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            req   <= 1'b0;
            done  <= 1'b0;
            tdata <= '0;
        end else begin
            state <= state_d;
            req   <= req_d;
            done  <= done_d;
            // data is captured a cycle before req rises so it is settled at the receiver
            if (pop) tdata <= head;
        end
    end

`ifdef SENDER_TWOFF_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset)    xfer_cnt <= '0;
        else if (done) xfer_cnt <= xfer_cnt + 16'd1;
    end

    assign drop = vi & full;
`endif

endmodule
